// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard detection and forwarding for a 5-stage core.
// Forwarding, load-use and branch-compare stalls are purely combinational.
// A small FSM holds the whole pipeline while data memory is busy. It forces a
// one-cycle release and sets a sticky mem_err flag when the wait exceeds
// MEM_TIMEOUT cycles.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// stall/flush performance counters. When it is undefined both counters read 0.

module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        branchD,
    input  logic        memtoregE,
    input  logic        regwriteE,
    input  logic        memtoregM,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        memreqM,
    input  logic        memreadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushE,
    output logic        flushW,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wcnt;
    logic [7:0] w_wcnt_nxt;
    logic       r_mem_err;
    logic       w_mem_err_nxt;
    logic       w_memstall;
    logic       w_lwstall;
    logic       w_branchstall;

    // Operand forwarding: the newest producer (M) wins over the older one (W).
    // Register 0 is hard-wired, so it is never forwarded.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rsE != 5'd0 && regwriteM && rsE == writeregM)      forwardAE = 2'b10;
        else if (rsE != 5'd0 && regwriteW && rsE == writeregW) forwardAE = 2'b01;
        if (rtE != 5'd0 && regwriteM && rtE == writeregM)      forwardBE = 2'b10;
        else if (rtE != 5'd0 && regwriteW && rtE == writeregW) forwardBE = 2'b01;
        forwardAD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
        forwardBD = (rtD != 5'd0) && regwriteM && (rtD == writeregM);
    end

    assign w_lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
    assign w_branchstall = branchD &
                           ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                            (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));

    // Memory-wait FSM next state and stall request. The timeout cycle itself
    // does not stall, so the pipeline gets a forced release.
    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_mem_err_nxt = r_mem_err;
        w_memstall    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (memreqM && !memreadyM) begin
                    w_memstall  = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wcnt_nxt  = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (memreadyM) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wcnt == TIMEOUT_CNT) begin
                    w_state_nxt   = ST_RELEASE;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_memstall = 1'b1;
                    w_wcnt_nxt = r_wcnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_RUN;
                w_wcnt_nxt  = 8'd0;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments, so every flop
            // samples values from before the clock edge.
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    assign mem_err = r_mem_err;

    // Stall/flush priority: a memory stall freezes everything and bubbles W.
    // Otherwise a load-use or branch hazard holds F/D and bubbles E.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (w_memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (w_lwstall || w_branchstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    // Saturating performance counters for stalled and flushed cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_cycles <= 32'd0;
        end else begin
            if (stallF && r_stall_cycles != 32'hFFFF_FFFF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if ((flushE || flushW) && r_flush_cycles != 32'hFFFF_FFFF)
                r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: drives two hazard_unit instances (MEM_TIMEOUT 255 and 3)
// with the same inputs. Outputs are compared every cycle against a
// behavioural model of the hazard rules. Directed scenarios add literal
// expectations on top of the model.

module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, memtoregE, regwriteE, memtoregM, regwriteM, regwriteW;
    logic       memreqM, memreadyM;

    logic [1:0]  o_sF, o_sD, o_sE, o_sM, o_fE, o_fW, o_fAD, o_fBD, o_err;
    logic [1:0]  o_fAE [2];
    logic [1:0]  o_fBE [2];
    logic [31:0] o_sc  [2];
    logic [31:0] o_fc  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .memtoregE(memtoregE), .regwriteE(regwriteE),
        .memtoregM(memtoregM), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memreqM(memreqM), .memreadyM(memreadyM),
        .stallF(o_sF[0]), .stallD(o_sD[0]), .stallE(o_sE[0]), .stallM(o_sM[0]),
        .flushE(o_fE[0]), .flushW(o_fW[0]), .forwardAD(o_fAD[0]), .forwardBD(o_fBD[0]),
        .forwardAE(o_fAE[0]), .forwardBE(o_fBE[0]), .mem_err(o_err[0]),
        .stall_cycles(o_sc[0]), .flush_cycles(o_fc[0])
    );

    hazard_unit #(.MEM_TIMEOUT(3)) dut_t (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .memtoregE(memtoregE), .regwriteE(regwriteE),
        .memtoregM(memtoregM), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memreqM(memreqM), .memreadyM(memreadyM),
        .stallF(o_sF[1]), .stallD(o_sD[1]), .stallE(o_sE[1]), .stallM(o_sM[1]),
        .flushE(o_fE[1]), .flushW(o_fW[1]), .forwardAD(o_fAD[1]), .forwardBD(o_fBD[1]),
        .forwardAE(o_fAE[1]), .forwardBE(o_fBE[1]), .mem_err(o_err[1]),
        .stall_cycles(o_sc[1]), .flush_cycles(o_fc[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: number of stalled cycles spent on the current memory
    // access (0 = no access outstanding), a pending forced-release cycle,
    // the sticky error flag and the two counters.
    int unsigned T [2] = '{255, 3};
    int unsigned m_n [2]     = '{0, 0};
    int unsigned m_n_nx [2]  = '{0, 0};
    bit          m_gap [2]   = '{0, 0};
    bit          m_gap_nx [2] = '{0, 0};
    bit          m_err [2]   = '{0, 0};
    bit          m_err_nx [2] = '{0, 0};
    logic [31:0] m_sc [2]    = '{0, 0};
    logic [31:0] m_sc_nx [2] = '{0, 0};
    logic [31:0] m_fc [2]    = '{0, 0};
    logic [31:0] m_fc_nx [2] = '{0, 0};
    int          rst_epoch = 0;
    int          nx_epoch  = -1;

    function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
        if (src != 0 && regwriteM && src == writeregM) return 2'd2;
        if (src != 0 && regwriteW && src == writeregW) return 2'd1;
        return 2'd0;
    endfunction

    // Reset wipes the model at once. A clock edge adopts the next state only
    // if it was computed after the most recent reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_epoch <= rst_epoch + 1;
            for (int i = 0; i < 2; i++) begin
                m_n[i] <= 0; m_gap[i] <= 0; m_err[i] <= 0; m_sc[i] <= 0; m_fc[i] <= 0;
            end
        end else if (nx_epoch == rst_epoch) begin
            for (int i = 0; i < 2; i++) begin
                m_n[i] <= m_n_nx[i]; m_gap[i] <= m_gap_nx[i]; m_err[i] <= m_err_nx[i];
                m_sc[i] <= m_sc_nx[i]; m_fc[i] <= m_fc_nx[i];
            end
        end
    end

    // Compare process: at every falling edge out of reset, check both
    // instances against the model and prepare the model's next state.
    bit         c_ms, c_lw, c_br;
    logic [5:0] c_exp_sf, c_exp_fwd;
    always @(negedge clk) begin
        if (rst) begin
            c_lw = memtoregE && (rtE == rsD || rtE == rtD);
            c_br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                               (memtoregM && (writeregM == rsD || writeregM == rtD)));
            c_exp_fwd = {rsD != 0 && regwriteM && rsD == writeregM,
                         rtD != 0 && regwriteM && rtD == writeregM,
                         exp_fwd_e(rsE), exp_fwd_e(rtE)};
            for (int i = 0; i < 2; i++) begin
                c_ms = 0;
                m_n_nx[i] = m_n[i]; m_gap_nx[i] = 0; m_err_nx[i] = m_err[i];
                if (m_gap[i]) begin
                    m_n_nx[i] = 0;
                end else if (m_n[i] == 0) begin
                    c_ms = memreqM && !memreadyM;
                    if (c_ms) m_n_nx[i] = 1;
                end else if (memreadyM) begin
                    m_n_nx[i] = 0;
                end else if (m_n[i] == T[i]) begin
                    m_err_nx[i] = 1; m_gap_nx[i] = 1; m_n_nx[i] = 0;
                end else begin
                    c_ms = 1; m_n_nx[i] = m_n[i] + 1;
                end
                // {stallF, stallD, stallE, stallM, flushE, flushW}
                c_exp_sf = c_ms ? 6'b111101 : (c_lw || c_br) ? 6'b110010 : 6'b000000;
                check($sformatf("stall_flush[%0d]", i),
                      32'({o_sF[i], o_sD[i], o_sE[i], o_sM[i], o_fE[i], o_fW[i]}), 32'(c_exp_sf));
                check($sformatf("forward[%0d]", i),
                      32'({o_fAD[i], o_fBD[i], o_fAE[i], o_fBE[i]}), 32'(c_exp_fwd));
                check($sformatf("mem_err[%0d]", i), 32'(o_err[i]), 32'(m_err[i]));
`ifdef HAZARD_PERF_CNT_EN
                check($sformatf("stall_cycles[%0d]", i), o_sc[i], m_sc[i]);
                check($sformatf("flush_cycles[%0d]", i), o_fc[i], m_fc[i]);
`else
                check($sformatf("stall_cycles[%0d]", i), o_sc[i], 32'd0);
                check($sformatf("flush_cycles[%0d]", i), o_fc[i], 32'd0);
`endif
                m_sc_nx[i] = (c_exp_sf[5] && m_sc[i] != 32'hFFFF_FFFF) ? m_sc[i] + 1 : m_sc[i];
                m_fc_nx[i] = ((c_exp_sf[1] || c_exp_sf[0]) && m_fc[i] != 32'hFFFF_FFFF)
                             ? m_fc[i] + 1 : m_fc[i];
            end
            nx_epoch = rst_epoch;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; memtoregE = 0; regwriteE = 0; memtoregM = 0; regwriteM = 0;
        regwriteW = 0; memreqM = 0; memreadyM = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 0;
        #1;
        rst = 1;
    endtask

    int n_stall;
    logic [31:0] exp_cnt;

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check("reset stallF", 32'(o_sF[0]), 32'd0);
        check("reset mem_err", 32'(o_err[0]), 32'd0);
        check("reset stall_cycles", o_sc[0], 32'd0);
        check("reset flush_cycles", o_fc[0], 32'd0);
        #1 rst = 1;

        // Forward from M to both E operands; register 0 is never forwarded.
        next_cycle();
        regwriteM = 1; writeregM = 5; rsE = 5; rtE = 5;
        @(negedge clk);
        check("fwdAE M", 32'(o_fAE[0]), 32'd2);
        check("fwdBE M", 32'(o_fBE[0]), 32'd2);
        next_cycle();
        rsE = 0;
        @(negedge clk);
        check("fwdAE r0", 32'(o_fAE[0]), 32'd0);

        // Load-use hazard.
        next_cycle();
        idle(); memtoregE = 1; rtE = 8; rsD = 8;
        @(negedge clk);
        check("lwstall sF/sD/fE", 32'({o_sF[0], o_sD[0], o_fE[0]}), 32'b111);
        check("lwstall stallE", 32'(o_sE[0]), 32'd0);

        // Branch comparand produced in E, then the conflict goes away.
        next_cycle();
        idle(); branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; rsD = 7;
        @(negedge clk);
        check("brstall sF/sD/fE", 32'({o_sF[0], o_sD[0], o_fE[0]}), 32'b111);
        next_cycle();
        writeregE = 0;
        @(negedge clk);
        check("brstall cleared", 32'({o_sF[0], o_sD[0], o_sE[0], o_sM[0], o_fE[0], o_fW[0]}), 32'd0);

        // Four-cycle memory wait on the default instance.
        next_cycle();
        idle(); reset_pulse(); memreqM = 1; memreadyM = 0;
        n_stall = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) memreadyM = 1;
            @(negedge clk);
            if (o_sF[0] && o_sD[0] && o_sE[0] && o_sM[0] && o_fW[0]) n_stall++;
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("memwait stall count", 32'(n_stall), 32'd4);
        check("memwait mem_err", 32'(o_err[0]), 32'd0);
        check("memwait back in RUN", 32'(o_sF[0]), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        exp_cnt = 32'd4;
`else
        exp_cnt = 32'd0;
`endif
        check("memwait stall_cycles", o_sc[0], exp_cnt);
        check("memwait flush_cycles", o_fc[0], exp_cnt);

        // Timeout on the MEM_TIMEOUT=3 instance, then async clear.
        next_cycle();
        reset_pulse(); memreqM = 1; memreadyM = 0;
        n_stall = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (o_sF[1]) n_stall++;
            if (c == 5) begin
                check("release no stall", 32'(o_sF[1]), 32'd0);
                check("timeout mem_err", 32'(o_err[1]), 32'd1);
            end
            next_cycle();
        end
        memreqM = 0;
        @(negedge clk);
        check("timeout stall count", 32'(n_stall), 32'd3);
        check("mem_err sticky", 32'(o_err[1]), 32'd1);
        #2 rst = 0;
        #1;
        check("async clear mem_err", 32'(o_err[1]), 32'd0);
        check("async clear stall_cycles", o_sc[0], 32'd0);
        rst = 1;
        next_cycle();
        @(negedge clk);
        check("wait abandoned", 32'(o_sF[0]), 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 1500; k++) begin
            next_cycle();
            rsD = 5'($urandom_range(0, 3));       rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));       rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            branchD = 1'($urandom_range(0, 1));   memtoregE = 1'($urandom_range(0, 1));
            regwriteE = 1'($urandom_range(0, 1)); memtoregM = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
            memreqM = 1'($urandom_range(0, 1));   memreadyM = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) reset_pulse();
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max MEM_WAIT cycles before forced release (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rsD, rtD  input  5 each  decode-stage source register numbers.
REQ-005 rsE, rtE, writeregE  input  5 each  execute-stage sources and destination.
REQ-006 writeregM, writeregW  input  5 each  memory/writeback destinations.
REQ-007 branchD, memtoregE, regwriteE, memtoregM, regwriteM, regwriteW  input  1 each  pipeline control flags from the controller.
REQ-008 memreqM  input  1  data-memory access active in M (load or store).
REQ-009 memreadyM  input  1  data memory completes the access this cycle.
REQ-010 stallF, stallD, stallE, stallM  output  1 each  hold stage register.
REQ-011 flushE, flushW  output  1 each  insert bubble into E / W register.
REQ-012 forwardAD, forwardBD  output  1 each  forward ALUOutM to branch comparator.
REQ-013 forwardAE, forwardBE  output  2 each  ALU operand select: 00 regfile, 01 ResultW, 10 ALUOutM.
REQ-014 mem_err  output  1  sticky memory-timeout flag.
REQ-015 stall_cycles, flush_cycles  output  32 each  performance counters (see Configuration).

Function
REQ-016 forwardAE SHALL be 10 when rsE!=0, regwriteM, rsE==writeregM; else 01 when rsE!=0, regwriteW, rsE==writeregW; else 00; forwardBE identical using rtE.
REQ-017 forwardAD SHALL be 1 iff rsD!=0, regwriteM, rsD==writeregM; forwardBD same with rtD.
REQ-018 lwstall SHALL be memtoregE & (rtE==rsD | rtE==rtD).
REQ-019 branchstall SHALL be branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
REQ-020 FSM states RUN, MEM_WAIT, RELEASE; 8-bit wait counter wcnt.
REQ-021 RUN: memreqM & !memreadyM -> MEM_WAIT, wcnt<=1; else stay.
REQ-022 MEM_WAIT: memreadyM -> RUN; else wcnt==MEM_TIMEOUT -> RELEASE and mem_err<=1; else wcnt<=wcnt+1.
REQ-023 RELEASE: unconditionally -> RUN after one cycle.
REQ-024 memstall (combinational) SHALL be (RUN & memreqM & !memreadyM) | (MEM_WAIT & !memreadyM & wcnt!=MEM_TIMEOUT); 0 in RELEASE.
REQ-025 memstall=1: stallF=stallD=stallE=stallM=1, flushW=1, flushE=0; lwstall/branchstall ignored.
REQ-026 memstall=0 and (lwstall|branchstall): stallF=stallD=flushE=1, stallE=stallM=flushW=0.
REQ-027 Otherwise all stall/flush outputs 0.
REQ-028 All stall, flush and forward outputs combinational, zero latency; FSM, wcnt, mem_err, counters registered.
REQ-029 mem_err SHALL remain 1 until reset.

Reset
REQ-030 rst low SHALL immediately force state=RUN, wcnt=0, mem_err=0, stall_cycles=0, flush_cycles=0, regardless of clk.
REQ-031 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release the FSM starts in RUN.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: stall_cycles increments each cycle stallF=1, flush_cycles each cycle flushE=1 or flushW=1; both saturate at 32'hFFFFFFFF.
REQ-033 Macro undefined: no counter registers; stall_cycles and flush_cycles tied to 0.

Verification
REQ-034 regwriteM=1, writeregM=5, rsE=5, rtE=5 -> forwardAE=forwardBE=10; rsE=0 same -> 00.
REQ-035 memtoregE=1, rtE=8, rsD=8, memreqM=0 -> stallF=stallD=flushE=1, stallE=0.
REQ-036 branchD=1, regwriteE=1, writeregE=3, rtD=3 -> stallF=stallD=flushE=1; next cycle writeregE=0 -> all 0.
REQ-037 memreqM=1, memreadyM=0 for 4 cycles then 1 -> stallF..stallM=flushW=1 for exactly 4 cycles, mem_err=0, FSM back in RUN.
REQ-038 MEM_TIMEOUT=3, memreadyM held 0 -> stalls high 3 cycles, one released cycle in RELEASE, mem_err=1 and sticky; rst low clears it asynchronously.
REQ-039 HAZARD_PERF_CNT_EN defined, scenario REQ-037 -> stall_cycles=4, flush_cycles=4; undefined -> both 0.
